// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
// ---------------
// Shares one single-port DRAM between four cores. One access is in flight at
// a time. Cores are chosen round-robin starting after the most recently
// granted core. A read grant also serves every other eligible core that reads
// the same address, and all of those cores see one shared completion strobe.
// Writes are always served one core at a time.
//
// Handshake (req / memAV): a core raises req[k] and holds req[k], we[k] and
// its AR/DR slices steady until memAV[k] pulses for one cycle. That pulse
// completes the access. In the cycle memAV[k] is high, req[k] is ignored, so
// the core has one cycle to drop or re-issue its request before it can be
// granted again. Once the arbiter latches a grant, the access runs to
// completion even if req[k] or core_en[k] drops.
//
// Ports
//   Clk, Rst_n         clock, asynchronous active-low reset
//   core_en[3:0]       per-core enable; a disabled core's req is ignored
//   req[3:0], we[3:0]  per-core request and write flag (1=write)
//   AR_bus, DR_bus     per-core address / write data, core k at [k*WIDTH +: WIDTH]
//   MEM                DRAM read data, valid the cycle after rEN is sampled
//   rEN, wEN           DRAM read / write enables (never both high)
//   addr, DR_OUT       DRAM address / write data, held while idle
//   MEM_bus            per-core registered read data, same slicing as AR_bus
//   memAV[3:0]         per-core one-cycle completion strobe
//   state_dbg          current arbiter state (IDLE=0, RD_ADDR=1, RD_DATA=2, WR=3)
module dmem_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [3:0]           core_en,
    input  logic [3:0]           req,
    input  logic [3:0]           we,
    input  logic [4*WIDTH-1:0]   AR_bus,
    input  logic [4*WIDTH-1:0]   DR_bus,
    input  logic [WIDTH-1:0]     MEM,
    output logic                 rEN,
    output logic                 wEN,
    output logic [WIDTH-1:0]     addr,
    output logic [WIDTH-1:0]     DR_OUT,
    output logic [4*WIDTH-1:0]   MEM_bus,
    output logic [3:0]           memAV,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           last_q, last_d;
    logic [3:0]           serve_q, serve_d;   // cores completed by the access in flight
    logic                 ren_q, ren_d;
    logic                 wen_q, wen_d;
    logic [WIDTH-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]     dr_out_q, dr_out_d;
    logic [4*WIDTH-1:0]   mem_bus_q, mem_bus_d;
    logic [3:0]           mem_av_q, mem_av_d;

    logic [WIDTH-1:0]     ar_a [4];
    logic [WIDTH-1:0]     dr_a [4];
    logic [3:0]           eligible;
    logic                 found;
    logic [1:0]           gnt_idx;
    logic [1:0]           cand;
    logic [3:0]           rd_match;

    // Unpack the buses and choose the round-robin winner.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ar_a[k] = AR_bus[k*WIDTH +: WIDTH];
            dr_a[k] = DR_bus[k*WIDTH +: WIDTH];
        end

        // A core that is being strobed this cycle cannot be granted again
        // until the next cycle.
        eligible = req & core_en & ~mem_av_q;

        found   = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            // Two-bit addition wraps, which gives (last+1+i) mod 4.
            cand = last_q + 2'(i) + 2'd1;
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end

        // Read coalescing set. The winner is always included because it
        // matches its own address.
        rd_match = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            rd_match[j] = eligible[j] & ~we[j] & (ar_a[j] == ar_a[gnt_idx]);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        serve_d   = serve_q;
        ren_d     = 1'b0;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        dr_out_d  = dr_out_q;
        mem_bus_d = mem_bus_q;
        mem_av_d  = 4'b0000;

        case (state_q)
            IDLE: begin
                if (found) begin
                    last_d = gnt_idx;
                    addr_d = ar_a[gnt_idx];
                    if (we[gnt_idx]) begin
                        wen_d    = 1'b1;
                        dr_out_d = dr_a[gnt_idx];
                        serve_d  = 4'b0001 << gnt_idx;
                        state_d  = WR;
                    end else begin
                        ren_d    = 1'b1;
                        serve_d  = rd_match;
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                for (int k = 0; k < 4; k++) begin
                    if (serve_q[k]) begin
                        mem_bus_d[k*WIDTH +: WIDTH] = MEM;
                    end
                end
                mem_av_d = serve_q;
                state_d  = IDLE;
            end
            WR: begin
                mem_av_d = serve_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            serve_q   <= 4'b0000;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            dr_out_q  <= '0;
            mem_bus_q <= '0;
            mem_av_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            serve_q   <= serve_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            dr_out_q  <= dr_out_d;
            mem_bus_q <= mem_bus_d;
            mem_av_q  <= mem_av_d;
        end
    end

    assign rEN       = ren_q;
    assign wEN       = wen_q;
    assign addr      = addr_q;
    assign DR_OUT    = dr_out_q;
    assign MEM_bus   = mem_bus_q;
    assign memAV     = mem_av_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Testbench for dmem_rr_arbiter (WIDTH=8). The expected outputs come from a
// transaction-level reference model. On each clock edge the model either
// picks a round-robin winner and starts a countdown of remaining edges, or
// counts down toward the completion strobe.
module tb_dmem_rr_arbiter;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic [3:0]     core_en, req, we;
    logic [W-1:0]   ar [4];
    logic [W-1:0]   dr [4];
    logic [4*W-1:0] AR_bus, DR_bus;
    logic [W-1:0]   MEM;
    logic           rEN, wEN;
    logic [W-1:0]   addr, DR_OUT;
    logic [4*W-1:0] MEM_bus;
    logic [3:0]     memAV;
    logic [1:0]     state_dbg;

    logic [W-1:0]   dram [256];

    int n_checks = 0;
    int n_errors = 0;

    assign AR_bus = {ar[3], ar[2], ar[1], ar[0]};
    assign DR_bus = {dr[3], dr[2], dr[1], dr[0]};

    dmem_rr_arbiter #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .core_en(core_en), .req(req), .we(we),
        .AR_bus(AR_bus), .DR_bus(DR_bus), .MEM(MEM),
        .rEN(rEN), .wEN(wEN), .addr(addr), .DR_OUT(DR_OUT),
        .MEM_bus(MEM_bus), .memAV(memAV), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    int           m_left;      // edges until the access in flight completes
    int           m_last;
    logic [3:0]   m_mask;
    bit           m_rd;
    logic         e_ren, e_wen;
    logic [W-1:0] e_addr, e_dr;
    logic [W-1:0] e_mb [4];
    logic [3:0]   e_av;

    wire [53:0] obs_vec = {rEN, wEN, addr, DR_OUT, memAV, MEM_bus};

    function automatic logic [53:0] exp_vec();
        return {e_ren, e_wen, e_addr, e_dr, e_av, e_mb[3], e_mb[2], e_mb[1], e_mb[0]};
    endfunction

    task automatic model_reset();
        m_left = 0; m_last = 3; m_mask = 4'b0; m_rd = 1'b0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_dr = '0; e_av = 4'b0;
        for (int k = 0; k < 4; k++) e_mb[k] = '0;
    endtask

    // Called right after a rising edge, while the inputs still hold the
    // values that were sampled at that edge.
    task automatic model_edge();
        logic [3:0] elig;
        int g;
        e_ren = 1'b0;
        e_wen = 1'b0;
        if (m_left == 0) begin
            elig = req & core_en & ~e_av;
            e_av = 4'b0;
            g = -1;
            for (int i = 1; i <= 4; i++)
                if (g < 0 && elig[(m_last + i) % 4]) g = (m_last + i) % 4;
            if (g >= 0) begin
                m_last = g;
                e_addr = ar[g];
                m_mask = 4'b0;
                if (we[g]) begin
                    e_wen = 1'b1; e_dr = dr[g]; m_left = 1; m_rd = 1'b0; m_mask[g] = 1'b1;
                end else begin
                    e_ren = 1'b1; m_left = 2; m_rd = 1'b1;
                    for (int j = 0; j < 4; j++)
                        if (elig[j] && !we[j] && ar[j] == ar[g]) m_mask[j] = 1'b1;
                end
            end
        end else begin
            e_av = 4'b0;
            m_left--;
            if (m_left == 0) begin
                e_av = m_mask;
                if (m_rd)
                    for (int j = 0; j < 4; j++) if (m_mask[j]) e_mb[j] = MEM;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle. Each call starts and ends 1 time unit after a
    // rising edge. MEM carries DRAM data only in the cycle after a sampled
    // rEN and carries random junk in every other cycle.
    task automatic step();
        logic         r;
        logic [W-1:0] a;
        r = rEN;
        a = addr;
        @(posedge Clk);
        if (Rst_n) model_edge();
        #1;
        MEM = r ? dram[a] : W'($urandom);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        model_reset();
        req = 4'b0; we = 4'b0; core_en = 4'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (obs_vec !== 54'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h exp=0", obs_vec);
        end
        n_checks++;
        if (state_dbg !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%0d exp=0", state_dbg);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int edges = 0, ren_cnt = 0;
        bit seen = 0;
        do_reset();
        core_en = 4'hF; we = 4'b0;
        ar[2] = 8'h10; dram[8'h10] = 8'h5A;
        req = 4'b0100;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            edges++;
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL single_read_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (rEN) begin
                ren_cnt++;
                n_checks++;
                if (addr !== 8'h10) begin
                    n_errors++;
                    $display("FAIL single_read_addr got=%h exp=10", addr);
                end
            end
            if (memAV[2]) begin seen = 1; req[2] = 1'b0; end
        end
        n_checks++;
        if (!seen || edges != 3) begin
            n_errors++;
            $display("FAIL single_read_latency got=%0d seen=%0d exp=3", edges, seen);
        end
        n_checks++;
        if (ren_cnt != 1) begin
            n_errors++;
            $display("FAIL single_read_ren_pulses got=%0d exp=1", ren_cnt);
        end
        n_checks++;
        if (MEM_bus[23:16] !== 8'h5A) begin
            n_errors++;
            $display("FAIL single_read_data got=%h exp=5a", MEM_bus[23:16]);
        end
    endtask

    task automatic test_round_robin();
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int cid;
        do_reset();
        for (int k = 0; k < 4; k++) begin ar[k] = 8'h40 + 8'(k); dr[k] = 8'hA0 + 8'(k); end
        core_en = 4'hF; we = 4'hF; req = 4'hF;
        for (int c = 0; c < 16 && n < 5; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL rr_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (wEN) begin
                cid = int'(addr) - 'h40;
                n_checks++;
                if (cid != exp_ord[n] || DR_OUT !== dr[exp_ord[n]]) begin
                    n_errors++;
                    $display("FAIL rr_grant%0d got=core%0d/dr=%h exp=core%0d/dr=%h",
                             n, cid, DR_OUT, exp_ord[n], dr[exp_ord[n]]);
                end
                n++;
            end
        end
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL rr_grant_count got=%0d exp=5", n);
        end
        req = 4'b0;
    endtask

    task automatic test_coalesce();
        int ev = 0, ren_cnt = 0;
        logic [3:0] exp_av;
        logic [W-1:0] exp_d;
        do_reset();
        ar[0] = 8'h20; ar[1] = 8'h20; ar[3] = 8'h20; ar[2] = 8'h21;
        dram[8'h20] = 8'h11; dram[8'h21] = 8'h22;
        core_en = 4'hF; we = 4'b0; req = 4'hF;
        for (int c = 0; c < 20 && ev < 2; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL coalesce_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (rEN) ren_cnt++;
            if (memAV != 4'b0) begin
                exp_av = (ev == 0) ? 4'b1011 : 4'b0100;
                exp_d  = (ev == 0) ? 8'h11 : 8'h22;
                n_checks++;
                if (memAV !== exp_av) begin
                    n_errors++;
                    $display("FAIL coalesce_av%0d got=%b exp=%b", ev, memAV, exp_av);
                end
                for (int k = 0; k < 4; k++) begin
                    if (exp_av[k]) begin
                        n_checks++;
                        if (MEM_bus[k*W +: W] !== exp_d) begin
                            n_errors++;
                            $display("FAIL coalesce_data%0d_core%0d got=%h exp=%h",
                                     ev, k, MEM_bus[k*W +: W], exp_d);
                        end
                    end
                end
                req = req & ~memAV;
                ev++;
            end
        end
        n_checks++;
        if (ev != 2 || ren_cnt != 2) begin
            n_errors++;
            $display("FAIL coalesce_count got=ev%0d/ren%0d exp=ev2/ren2", ev, ren_cnt);
        end
    endtask

    task automatic test_mask();
        int served0 = 0, served1 = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin ar[k] = W'($urandom); dr[k] = W'($urandom); end
        we = 4'($urandom_range(0, 15));
        core_en = 4'b0011; req = 4'hF;
        for (int c = 0; c < 24; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec() || memAV[3:2] !== 2'b00) begin
                n_errors++;
                $display("FAIL mask_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (memAV[0]) served0++;
            if (memAV[1]) served1++;
        end
        n_checks++;
        if (served0 == 0 || served1 == 0) begin
            n_errors++;
            $display("FAIL mask_served got=%0d/%0d exp=nonzero", served0, served1);
        end
        req = 4'b0;
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        do_reset();
        core_en = 4'hF; we = 4'b0;
        ar[1] = 8'h33; dram[8'h33] = 8'h77; req = 4'b0010;
        repeat (2) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL rmid_pre got=%h exp=%h", obs_vec, exp_vec());
            end
        end
        // The access is now in its data phase. Abort it.
        Rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL rmid_reset_vals got=%h exp=%h", obs_vec, exp_vec());
        end
        repeat (3) begin
            step();
            n_checks++;
            if (memAV !== 4'b0) begin
                n_errors++;
                $display("FAIL rmid_no_strobe got=%b exp=0000", memAV);
            end
        end
        Rst_n = 1'b1;
        ar[0] = 8'h44; dram[8'h44] = 8'h99; req = 4'b0011;
        for (int c = 0; c < 20 && req != 4'b0; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL rmid_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (rEN && !got) begin
                got = 1;
                n_checks++;
                if (addr !== 8'h44) begin
                    n_errors++;
                    $display("FAIL rmid_first_grant got=%h exp=44", addr);
                end
            end
            req = req & ~memAV;
        end
        n_checks++;
        if (req != 4'b0) begin
            n_errors++;
            $display("FAIL rmid_timeout got=%b exp=0000", req);
        end
    endtask

    task automatic test_turnaround();
        int exp_ord [3] = '{0, 1, 0};
        int n = 0;
        int cid;
        do_reset();
        ar[0] = 8'h50; ar[1] = 8'h51; dr[0] = 8'hC0; dr[1] = 8'hC1;
        core_en = 4'hF; we = 4'b0011; req = 4'b0011;
        for (int c = 0; c < 12 && n < 3; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL turn_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            if (wEN) begin
                cid = int'(addr) - 'h50;
                n_checks++;
                if (cid != exp_ord[n]) begin
                    n_errors++;
                    $display("FAIL turn_grant%0d got=core%0d exp=core%0d", n, cid, exp_ord[n]);
                end
                n++;
            end
        end
        n_checks++;
        if (n != 3) begin
            n_errors++;
            $display("FAIL turn_count got=%0d exp=3", n);
        end
        req = 4'b0;
    endtask

    task automatic test_random();
        int t;
        do_reset();
        core_en = 4'hF; req = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec() || (rEN && wEN)) begin
                n_errors++;
                $display("FAIL random_cyc%0d got=%h exp=%h", c, obs_vec, exp_vec());
            end
            for (int k = 0; k < 4; k++) begin
                if (memAV[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    ar[k]  = W'($urandom_range(0, 3));
                    we[k]  = 1'($urandom_range(0, 1));
                    dr[k]  = W'($urandom);
                    req[k] = 1'b1;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                t = $urandom_range(0, 3);
                core_en[t] = ~core_en[t];
            end
        end
    endtask

    // ---------------- main sequence / final report ----------------
    initial begin
        Rst_n = 1'b0;
        core_en = 4'b0; req = 4'b0; we = 4'b0; MEM = '0;
        for (int k = 0; k < 4; k++) begin ar[k] = '0; dr[k] = '0; end
        for (int i = 0; i < 256; i++) dram[i] = W'($urandom);
        model_reset();
        @(posedge Clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_coalesce();
        test_mask();
        test_reset_mid();
        test_turnaround();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
